// File: rtl/tag_verifier_pkg.sv
// tag_verifier_pkg: tag-path constants and verifier FSM encoding shared by the AEAD tag logic
package tag_verifier_pkg;
  localparam int TAG_W = 128;
  typedef enum logic [1:0] {IDLE = 2'd0, COMPARE = 2'd1, RESULT = 2'd2} state_t;
endpackage

// File: rtl/tag_verifier_ct_compare.sv
// ct_compare: constant-time tag equality, one W-bit chunk per cycle, most significant chunk first
module ct_compare
  import tag_verifier_pkg::*;
#(
  parameter int W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [TAG_W-1:0] a,
  input  logic [TAG_W-1:0] b,
  output logic             done,
  output logic             equal
);
  localparam int N = TAG_W / W;
  localparam int CTR_W = $clog2(N) + 1;
  logic [W-1:0] diff, chunk;
  logic [CTR_W-1:0] ctr;
  logic run;
  assign chunk = W'((a ^ b) >> (TAG_W - W - W * int'(ctr)));
  assign done = run && ctr == CTR_W'(N - 1);
  assign equal = (diff | chunk) == '0;
  // clear on start, then fold every chunk in for exactly N cycles regardless of the data
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      diff <= '0;
      ctr <= '0;
      run <= 1'b0;
    end else if (start) begin
      diff <= '0;
      ctr <= '0;
      run <= 1'b1;
    end else if (run) begin
      diff <= diff | chunk;
      ctr <= ctr + 1'b1;
      run <= !done;
    end
endmodule

// File: rtl/tag_verifier.sv
// tag_verifier: constant-time AEAD tag check that gates plaintext release and counts failures
module tag_verifier
  import tag_verifier_pkg::*;
#(
  parameter int y = 40,
  parameter int W = 32,
  parameter int FCW = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       dec_ready,
  input  logic [(y > 0 ? y : 1)-1:0] dec_plain,
  input  logic [TAG_W-1:0]           dec_tag,
  input  logic [TAG_W-1:0]           rx_tag,
  input  logic                       out_ack,
  output logic                       busy,
  output logic                       out_valid,
  output logic                       tag_ok,
  output logic [(y > 0 ? y : 1)-1:0] plain_out,
  output logic [FCW-1:0]             fail_count
);
  state_t state, state_next;
  logic rdy_q, start, ok_q, done, equal;
  logic [TAG_W-1:0] tag_q, rx_q;
  // only a rising edge of ready seen while idle starts a check; edges in other states are dropped
  assign start = dec_ready && !rdy_q && state == IDLE;
  ct_compare #(.W(W)) u_cmp (
    .clk(clk),
    .rst(rst),
    .start(start),
    .a(tag_q),
    .b(rx_q),
    .done(done),
    .equal(equal)
  );
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_next;
  // next state; unused encodings fall back to IDLE
  always_comb
    state_next = state == IDLE    ? (start ? COMPARE : IDLE)
               : state == COMPARE ? (done ? RESULT : COMPARE)
               : state == RESULT  ? (out_ack ? IDLE : RESULT)
               : IDLE;
  // outputs; the verdict is only visible while RESULT holds
  always_comb begin
    busy = state == COMPARE || state == RESULT;
    out_valid = state == RESULT;
    tag_ok = out_valid && ok_q;
  end
  // ready edge detector, tag captures, verdict latch and saturating failure counter
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rdy_q <= 1'b0;
      tag_q <= '0;
      rx_q <= '0;
      ok_q <= 1'b0;
      fail_count <= '0;
    end else begin
      rdy_q <= dec_ready;
      if (start) begin
        tag_q <= dec_tag;
        rx_q <= rx_tag;
      end
      if (state == COMPARE && done) begin
        ok_q <= equal;
        if (!equal && fail_count != '1) fail_count <= fail_count + 1'b1;
      end
    end
  if (y > 0) begin : g_plain
    logic [y-1:0] plain_q;
    // plaintext capture, released only behind a good verdict
    always_ff @(posedge clk or negedge rst)
      if (!rst) plain_q <= '0;
      else if (start) plain_q <= dec_plain;
    assign plain_out = tag_ok ? plain_q : '0;
  end else begin : g_no_plain
    logic unused_plain;
    assign unused_plain = ^dec_plain;
    assign plain_out = 1'b0;
  end
endmodule

// File: tb/tb_tag_verifier.sv
// tb_tag_verifier: directed and randomized checks of tag_verifier against a verdict/count model
module tb_tag_verifier;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic dec_ready = 1'b0, out_ack = 1'b0;
  logic [39:0] dec_plain = '0;
  logic [127:0] dec_tag = '0, rx_tag = '0;
  logic busy, out_valid, tag_ok;
  logic [39:0] plain_out;
  logic [7:0] fail_count;
  logic b1, v1, k1;
  logic [39:0] p1;
  logic [1:0] fc1;
  logic rdy2 = 1'b0, ack2 = 1'b0, plain2 = 1'b1;
  logic [127:0] tag2 = '0, rx2 = '0;
  logic b2, v2, k2, p2;
  logic [7:0] fc2;
  int total = 0, bad = 0;
  int m_fc0 = 0, m_fc1 = 0, m_fc2 = 0;
  always #5 clk = ~clk;
  tag_verifier u0 (
    .clk(clk), .rst(rst), .dec_ready(dec_ready), .dec_plain(dec_plain), .dec_tag(dec_tag),
    .rx_tag(rx_tag), .out_ack(out_ack), .busy(busy), .out_valid(out_valid), .tag_ok(tag_ok),
    .plain_out(plain_out), .fail_count(fail_count)
  );
  tag_verifier #(.FCW(2)) u1 (
    .clk(clk), .rst(rst), .dec_ready(dec_ready), .dec_plain(dec_plain), .dec_tag(dec_tag),
    .rx_tag(rx_tag), .out_ack(out_ack), .busy(b1), .out_valid(v1), .tag_ok(k1),
    .plain_out(p1), .fail_count(fc1)
  );
  tag_verifier #(.y(0), .W(128)) u2 (
    .clk(clk), .rst(rst), .dec_ready(rdy2), .dec_plain(plain2), .dec_tag(tag2),
    .rx_tag(rx2), .out_ack(ack2), .busy(b2), .out_valid(v2), .tag_ok(k2),
    .plain_out(p2), .fail_count(fc2)
  );
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  // one verification on u0/u1: ready rises just after an edge, verdict expected N+1 edges later
  task automatic run(input logic [39:0] p, input logic [127:0] dt, input logic [127:0] rt,
                     input bit hold, input bit glitch, input int ackwait);
    bit ok = dt == rt;
    dec_plain = p; dec_tag = dt; rx_tag = rt; dec_ready = 1'b1; out_ack = 1'b0;
    cyc(1);
    if (!hold) dec_ready = 1'b0;
    check("busy_start", 128'(busy), 128'(1));
    if (glitch) begin
      dec_ready = 1'b0;
      cyc(1);
      dec_ready = 1'b1; dec_plain = ~p; dec_tag = ~dt; rx_tag = ok ? (~dt ^ 128'd1) : ~dt;
      cyc(2);
      dec_ready = 1'b0;
    end else cyc(3);
    check("valid_early", 128'(out_valid), 128'(0));
    cyc(1);
    if (!ok) begin
      if (m_fc0 < 255) m_fc0++;
      if (m_fc1 < 3) m_fc1++;
    end
    check("valid", 128'(out_valid), 128'(1));
    check("tag_ok", 128'(tag_ok), 128'(ok));
    check("plain_out", 128'(plain_out), 128'(ok ? p : 40'h0));
    check("fail_count", 128'(fail_count), 128'(m_fc0));
    check("fc_sat", 128'(fc1), 128'(m_fc1));
    if (ackwait > 0) begin
      cyc(ackwait);
      check("valid_hold", 128'({out_valid, tag_ok}), 128'({1'b1, ok}));
    end
    out_ack = 1'b1;
    cyc(1);
    out_ack = 1'b0;
    check("after_ack", 128'({busy, out_valid, tag_ok, plain_out}), 128'(0));
    if (hold || glitch) begin
      cyc(8);
      check("no_restart", 128'({busy, fail_count}), 128'({1'b0, 8'(m_fc0)}));
    end
    dec_ready = 1'b0;
    cyc(1);
  endtask
  // one verification on the W=128, y=0 instance
  task automatic run2(input logic [127:0] dt, input logic [127:0] rt);
    bit ok = dt == rt;
    tag2 = dt; rx2 = rt; rdy2 = 1'b1; ack2 = 1'b0;
    cyc(1);
    rdy2 = 1'b0;
    check("w128_early", 128'(v2), 128'(0));
    cyc(1);
    if (!ok && m_fc2 < 255) m_fc2++;
    check("w128_verdict", 128'({v2, k2, p2}), 128'({1'b1, ok, 1'b0}));
    check("w128_count", 128'(fc2), 128'(m_fc2));
    ack2 = 1'b1;
    cyc(1);
    ack2 = 1'b0;
    check("w128_ack", 128'({b2, v2, k2}), 128'(0));
  endtask
  initial begin
    logic [127:0] t;
    cyc(2);
    check("reset_out", 128'({busy, out_valid, tag_ok, plain_out, fail_count}), 128'(0));
    #2 rst = 1'b1;
    cyc(2);
    t = 128'h0123456789ABCDEF_FEDCBA9876543210;
    run(40'hDEADBEEF01, t, t, 1'b0, 1'b0, 0);
    run(40'hDEADBEEF01, t, t ^ 128'd1, 1'b0, 1'b0, 0);
    run(40'hDEADBEEF01, t, t ^ (128'd1 << 127), 1'b0, 1'b0, 0);
    t = rnd128();
    run(40'({$urandom, $urandom}), t, t ^ (128'd1 << $urandom_range(127, 0)), 1'b1, 1'b0, 6);
    t = rnd128();
    run(40'({$urandom, $urandom}), t, t, 1'b0, 1'b1, 0);
    for (int i = 0; i < 6; i++) begin
      t = rnd128();
      run(40'({$urandom, $urandom}), t, $urandom_range(1, 0) != 0 ? t : rnd128(), 1'b0, 1'b0,
          $urandom_range(3, 0));
    end
    t = rnd128();
    dec_plain = 40'h1122334455; dec_tag = t; rx_tag = ~t; dec_ready = 1'b1;
    cyc(1);
    dec_ready = 1'b0;
    cyc(2);
    #3 rst = 1'b0;
    #1;
    m_fc0 = 0; m_fc1 = 0; m_fc2 = 0;
    check("async_reset", 128'({busy, out_valid, tag_ok, plain_out, fail_count, fc1}), 128'(0));
    #2 rst = 1'b1;
    cyc(6);
    check("abort_no_verdict", 128'({busy, out_valid, fail_count}), 128'(0));
    t = rnd128();
    run(40'hCAFEF00D99, t, t, 1'b0, 1'b0, 1);
    for (int i = 0; i < 5; i++) begin
      t = rnd128();
      run(40'({$urandom, $urandom}), t, t ^ (128'd1 << $urandom_range(127, 0)), 1'b0, 1'b0, 0);
    end
    for (int i = 0; i < 6; i++) begin
      t = rnd128();
      run2(t, i % 2 == 0 ? t : t ^ (128'd1 << $urandom_range(127, 0)));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
